ex_muldiv_unit: RTL

- Parametrised multi-cycle M-extension execute unit that sits beside the EX-stage ALU.
- Takes operands from the ID/EX pipeline register when the decoded op is RV32M (opcode OP, func7=0000001) and returns a tagged result toward the MEM stage through a valid/ready handshake.
- Multiply uses a fixed-latency registered pipeline; divide/remainder uses an iterative restoring divider (1 quotient bit per cycle).
- Exactly one operation is in flight at a time; the EX stage stalls while o_ready is low.

---
 rtl/ex_muldiv_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: fixed-latency multiplier plus iterative restoring divider, one op in flight.
// Optional: define MULDIV_EARLY_OUT_EN to short-cut divides whose |A| < |B|.
module ex_muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_func3,
    input  logic [XLEN-1:0]  i_A,
    input  logic [XLEN-1:0]  i_B,
    input  logic [TAG_W-1:0] i_rd,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_rd
);

    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_SPEC, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_q;     // func3[1:0]; func3[2] only steers the state path
    logic [XLEN-1:0]    a_q, b_q;
    logic [TAG_W-1:0]   rd_q;
    logic [CNT_W-1:0]   cnt;
    logic [XLEN-1:0]    rem_q, quo_q, dvs_q;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    // Accept-time classification of divides
    logic accept, in_signed, in_spec;
    always_comb begin
        accept    = i_valid && (state == S_IDLE) && !i_flush;
        in_signed = !i_func3[0];
        in_spec   = (i_B == '0) || (in_signed && i_A == SMIN && i_B == '1);
`ifdef MULDIV_EARLY_OUT_EN
        if (mag(i_A, in_signed) < mag(i_B, in_signed))
            in_spec = 1'b1;
`endif
    end

    // Multiplier: operands extended to 2*XLEN so one unsigned product covers all sign modes
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   mul_res;
    always_comb begin
        mul_a   = {{XLEN{(op_q != 2'b11) & a_q[XLEN-1]}}, a_q};
        mul_b   = {{XLEN{!op_q[1] & b_q[XLEN-1]}}, b_q};
        prod    = mul_a * mul_b;
        mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Divider step; the extra bit of the trial difference is the borrow
    logic [XLEN:0]   shifted, diff;
    logic            q_neg, r_neg, d0, ovf;
    logic [XLEN-1:0] div_res, spec_res;
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        q_neg   = !op_q[0] && (a_q[XLEN-1] ^ b_q[XLEN-1]);
        r_neg   = !op_q[0] && a_q[XLEN-1];
        div_res = op_q[1] ? (r_neg ? -rem_q : rem_q) : (q_neg ? -quo_q : quo_q);
        d0      = (b_q == '0);
        ovf     = !op_q[0] && (a_q == SMIN) && (b_q == '1);
        if (d0)
            spec_res = op_q[1] ? a_q : '1;
        else if (ovf)
            spec_res = op_q[1] ? '0 : a_q;
        else
            spec_res = op_q[1] ? a_q : '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = !i_func3[2] ? S_MUL : (in_spec ? S_SPEC : S_DIV);
            S_MUL:  if (cnt == MUL_LAST) state_nxt = S_DONE;
            S_DIV:  if (cnt == DIV_LAST) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_SPEC: state_nxt = S_DONE;
            S_DONE: if (i_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (i_flush && state != S_IDLE)
            state_nxt = S_IDLE;
    end

    assign o_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: these are plain registers, not a memory, so all of them are cleared on reset.
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            o_result <= '0;
            o_rd     <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q <= i_func3[1:0];
                    a_q  <= i_A;
                    b_q  <= i_B;
                    rd_q <= i_rd;
                    cnt  <= '0;
                end
                S_MUL: begin
                    if (cnt != MUL_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (!i_flush) begin
                        o_result <= mul_res;
                        o_rd     <= rd_q;
                    end
                end
                S_DIV: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == '0) begin
                        rem_q <= '0;
                        quo_q <= mag(a_q, !op_q[0]);
                        dvs_q <= mag(b_q, !op_q[0]);
                    end else if (!diff[XLEN]) begin
                        rem_q <= diff[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b0};
                    end
                end
                S_FIX: if (!i_flush) begin
                    o_result <= div_res;
                    o_rd     <= rd_q;
                end
                S_SPEC: if (!i_flush) begin
                    o_result <= spec_res;
                    o_rd     <= rd_q;
                end
                default: ;
            endcase
        end
    end

endmodule
